// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data-memory arbiter with bounded burst
// Registered per-port read data, completion pulse and error flag.
module dmem_arbiter #(
    parameter int ADDR_LIMIT = 400,
    parameter int MAX_BURST  = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    output logic        p0_rvalid,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        p1_rvalid,
    output logic        p1_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [31:0]      LIMIT   = 32'(ADDR_LIMIT);

    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic        p0_rvalid_q, p0_rvalid_d;
    logic        p0_err_q, p0_err_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;
    logic        p1_rvalid_q, p1_rvalid_d;
    logic        p1_err_q, p1_err_d;

    logic        gnt_valid;
    logic        gnt_port;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        err_now;

    // The burst counter only matters under contention; a lone requester always wins.
    always_comb begin
        gnt_valid = (p0_req | p1_req) & ~reset;
        gnt_port  = 1'b0;
        if (p0_req && p1_req) begin
            gnt_port = (cnt_q >= MAX_CNT) ? ~last_q : last_q;
        end else if (p1_req) begin
            gnt_port = 1'b1;
        end
    end

    always_comb begin
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        sel_we    = p0_we;
        if (gnt_valid && gnt_port) begin
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
            sel_we    = p1_we;
        end
        err_now = (sel_addr >= LIMIT) || (sel_addr[1:0] != 2'b00);
    end

    // Erroneous accesses are still acked but never reach the memory.
    assign p0_ack    = gnt_valid & ~gnt_port;
    assign p1_ack    = gnt_valid & gnt_port;
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;
    assign mem_read  = gnt_valid & ~sel_we & ~err_now;
    assign mem_write = gnt_valid & sel_we & ~err_now;

    always_comb begin
        last_d = last_q;
        cnt_d  = cnt_q;
        if (!gnt_valid) begin
            cnt_d = '0;
        end else if (gnt_port == last_q) begin
            cnt_d = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + CNT_W'(1);
        end else begin
            last_d = gnt_port;
            cnt_d  = CNT_W'(1);
        end
    end

    always_comb begin
        p0_rdata_d  = p0_rdata_q;
        p0_rvalid_d = p0_ack;
        p0_err_d    = p0_ack & err_now;
        if (p0_ack && !sel_we) begin
            p0_rdata_d = err_now ? 32'h0 : mem_rdata;
        end
        p1_rdata_d  = p1_rdata_q;
        p1_rvalid_d = p1_ack;
        p1_err_d    = p1_ack & err_now;
        if (p1_ack && !sel_we) begin
            p1_rdata_d = err_now ? 32'h0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q      <= 1'b0;
            cnt_q       <= '0;
            p0_rdata_q  <= '0;
            p0_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_rdata_q  <= '0;
            p1_rvalid_q <= 1'b0;
            p1_err_q    <= 1'b0;
        end else begin
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            p0_rdata_q  <= p0_rdata_d;
            p0_rvalid_q <= p0_rvalid_d;
            p0_err_q    <= p0_err_d;
            p1_rdata_q  <= p1_rdata_d;
            p1_rvalid_q <= p1_rvalid_d;
            p1_err_q    <= p1_err_d;
        end
    end

    assign p0_rdata  = p0_rdata_q;
    assign p0_rvalid = p0_rvalid_q;
    assign p0_err    = p0_err_q;
    assign p1_rdata  = p1_rdata_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p1_err    = p1_err_q;

endmodule
